// File: rtl/data_memory_if.sv
// Load/store bus between the CPU datapath and the byte-addressed data memory.
// Latency: none of its own; carries the 16-bit address/data and enables.
// Backpressure: none; the memory always accepts a write and answers a read.
interface data_memory_if;
    logic [15:0] Adresa;
    logic [15:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [15:0] ReadData;

    // Datapath side: drives address, data and enables, receives the read word.
    modport master (
        output Adresa,
        output WriteData,
        output MemWrite,
        output MemRead,
        input  ReadData
    );

    // Memory side.
    modport slave (
        input  Adresa,
        input  WriteData,
        input  MemWrite,
        input  MemRead,
        output ReadData
    );
endinterface

// File: rtl/data_memory.sv
// Byte-addressed data memory storing 16-bit words big-endian over two bytes.
// Latency: writes land on the rising Clock edge; reads are combinational.
// Backpressure: none; every cycle may read and/or write, reset blocks writes.
module data_memory #(
    parameter int ADDR_BITS = 8
) (
    data_memory_if.slave bus,
    input  logic         Clock,
    input  logic         ResetN
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [7:0]           mem [DEPTH];
    logic [ADDR_BITS-1:0] addr_hi;
    logic [ADDR_BITS-1:0] addr_lo;

    // Upper address bits are dropped so addresses alias; the low byte of a
    // word sits one above the high byte and wraps from the top back to 0.
    always_comb begin
        addr_hi = bus.Adresa[ADDR_BITS-1:0];
        addr_lo = addr_hi + ADDR_BITS'(1);
    end

    // Byte array: cleared asynchronously, two bytes written per enabled edge.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (bus.MemWrite) begin
            mem[addr_hi] <= bus.WriteData[15:8];
            mem[addr_lo] <= bus.WriteData[7:0];
        end
    end

    // Combinational read, forced to zero while disabled or held in reset.
    always_comb begin
        bus.ReadData = 16'h0000;
        if (ResetN && bus.MemRead) begin
            bus.ReadData = {mem[addr_hi], mem[addr_lo]};
        end
    end
endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
    logic clk;
    logic rst_n;

    data_memory_if bus ();

    data_memory #(.ADDR_BITS(8)) dut (
        .bus    (bus),
        .Clock  (clk),
        .ResetN (rst_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_q  [$];
    string       name_q [$];

    typedef struct packed {
        logic [15:0] adresa;
        logic [15:0] wdata;
        logic        mw;
        logic        mr;
        logic [15:0] exp_pre;
        logic [15:0] exp_post;
    } vec_t;

    vec_t vecs [15];

    task automatic drive(input logic [15:0] a, input logic [15:0] wd,
                         input logic mw, input logic mr);
        bus.Adresa    = a;
        bus.WriteData = wd;
        bus.MemWrite  = mw;
        bus.MemRead   = mr;
    endtask

    // Queue the expectation now, sample the DUT 1 time unit later.
    task automatic check(input string nm, input logic [15:0] exp);
        logic [15:0] e;
        string       n;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        #1;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        n_cmp++;
        if (bus.ReadData !== e) begin
            n_bad++;
            $display("FAIL %s: ReadData=%h required %h", n, bus.ReadData, e);
        end
    endtask

    initial begin
        //          adresa     wdata     mw    mr    pre       post
        vecs[0]  = '{16'd15,   16'h0789, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{16'd15,   16'h0000, 1'b0, 1'b1, 16'h0789, 16'h0789};
        vecs[2]  = '{16'd16,   16'h0000, 1'b0, 1'b1, 16'h8900, 16'h8900};
        vecs[3]  = '{16'd14,   16'h0000, 1'b0, 1'b1, 16'h0007, 16'h0007};
        vecs[4]  = '{16'd15,   16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[5]  = '{16'd15,   16'h0000, 1'b0, 1'b1, 16'h0789, 16'h0789};
        vecs[6]  = '{16'd255,  16'hABCD, 1'b1, 1'b1, 16'h0000, 16'hABCD};
        vecs[7]  = '{16'd255,  16'h0000, 1'b0, 1'b1, 16'hABCD, 16'hABCD};
        vecs[8]  = '{16'd0,    16'h0000, 1'b0, 1'b1, 16'hCD00, 16'hCD00};
        vecs[9]  = '{16'h010F, 16'h1234, 1'b1, 1'b1, 16'h0789, 16'h1234};
        vecs[10] = '{16'd15,   16'hFFFF, 1'b0, 1'b1, 16'h1234, 16'h1234};
        vecs[11] = '{16'h010F, 16'hFFFF, 1'b0, 1'b1, 16'h1234, 16'h1234};
        vecs[12] = '{16'd16,   16'h0000, 1'b0, 1'b1, 16'h3400, 16'h3400};
        vecs[13] = '{16'd20,   16'hBEEF, 1'b1, 1'b1, 16'h0000, 16'hBEEF};
        vecs[14] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'hABCD, 16'hABCD};

        // Reset pulse; output must be zero even with MemRead high.
        rst_n = 1'b0;
        drive(16'd15, 16'h0000, 1'b0, 1'b1);
        check("reset_out", 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_reset_read", 16'h0000);

        // Table-driven vectors: check before and after each rising edge.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].adresa, vecs[i].wdata, vecs[i].mw, vecs[i].mr);
            check($sformatf("vec%0d_pre", i), vecs[i].exp_pre);
            @(posedge clk);
            check($sformatf("vec%0d_post", i), vecs[i].exp_post);
        end

        // Read gating toggled with no clock edge in between.
        @(negedge clk);
        drive(16'd15, 16'h0000, 1'b0, 1'b0);
        check("gate_off", 16'h0000);
        bus.MemRead = 1'b1;
        check("gate_on", 16'h1234);

        // Async reset between edges takes effect immediately.
        #1;
        rst_n = 1'b0;
        check("async_reset_now", 16'h0000);
        drive(16'd15, 16'h5555, 1'b1, 1'b1);
        @(posedge clk);
        check("write_blocked_in_reset", 16'h0000);
        @(negedge clk);
        drive(16'd15, 16'h0000, 1'b0, 1'b1);
        rst_n = 1'b1;
        check("cleared_15", 16'h0000);
        bus.Adresa = 16'd255;
        check("cleared_255", 16'h0000);
        bus.Adresa = 16'd20;
        check("cleared_20", 16'h0000);

        // Reset asserted at the same instant as a write edge: nothing stored.
        @(negedge clk);
        drive(16'd30, 16'hAAAA, 1'b1, 1'b1);
        @(posedge clk);
        rst_n = 1'b0;
        check("reset_vs_edge_out", 16'h0000);
        @(negedge clk);
        bus.MemWrite = 1'b0;
        rst_n = 1'b1;
        check("reset_vs_edge_mem", 16'h0000);

        // First write accepted on the first rising edge after release.
        @(negedge clk);
        rst_n = 1'b0;
        drive(16'd40, 16'hC0DE, 1'b1, 1'b1);
        #2;
        rst_n = 1'b1;
        check("first_write_pre", 16'h0000);
        @(posedge clk);
        check("first_write_post", 16'hC0DE);

        // Simultaneous read and write on a fresh location.
        @(negedge clk);
        drive(16'd20, 16'hBEEF, 1'b1, 1'b1);
        check("rw_same_pre", 16'h0000);
        @(posedge clk);
        check("rw_same_post", 16'hBEEF);
        @(negedge clk);
        drive(16'd21, 16'h0000, 1'b0, 1'b1);
        check("rw_overlap_21", 16'hEF00);
        bus.Adresa = 16'd39;
        check("neighbour_39", 16'h00C0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
